alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised successor to the single-cycle integer ALU. Executes RV32I/RV64I register ALU ops plus the
//  M extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU) behind a valid/ready handshake.
//  Base ops complete in one cycle; multiply and divide use iterative shift-add / restoring-divide FSMs.
//  Sits between register-read and writeback in the core; stalls issue via in_ready.
// PARAMETERS
//  XLEN    32  operand/result width (32 or 64); shamt = rs2[$clog2(XLEN)-1:0]
// PORTS
//  clk        in   1     clock; all state on rising edge
//  rst_n      in   1     synchronous active-low reset
//  in_valid   in   1     operation presented
//  in_ready   out  1     unit can accept; accept = in_valid && in_ready
//  funct7     in   7     0000000 base, 0100000 SUB/SRA, 0000001 M-ext; anything else is illegal
//  funct3     in   3     RISC-V funct3
//  rs1, rs2   in   XLEN  operands
//  out_valid  out  1     result held valid until out_ready
//  out_ready  in   1     consumer takes result; handoff = out_valid && out_ready
//  rd         out  XLEN  result
//  eq         out  1     rs1==rs2 of the accepted op, registered with rd
//  illegal    out  1     funct7/funct3 combination not decoded; rd=0
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, rd=0, eq=0, illegal=0; any in-flight mul/div is discarded, no output.
//  States: IDLE, MUL, DIV. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Base op accepted in cycle N: rd/eq/illegal registered, out_valid=1 in N+1. Back-to-back 1 op/cycle.
//   ADD/SUB wrap mod 2^XLEN; SLL/SRL/SRA use the low log2(XLEN) bits of rs2; SLT signed, SLTU unsigned
//   (rd = 0 or 1); XOR/OR/AND bitwise. SUB/SRA only with funct7=0100000; other 0100000 funct3 is illegal.
//  MUL* accepted at N: IDLE->MUL, XLEN iterations of 1 bit/cycle on a 2*XLEN product register,
//   sign-corrected per op; out_valid at N+XLEN+1, state->IDLE.
//   MUL returns low half; MULH signed x signed high; MULHSU signed rs1 x unsigned rs2 high; MULHU high.
//  DIV* accepted at N: IDLE->DIV, restoring divide on magnitudes, XLEN cycles, then sign fix; out_valid
//   at N+XLEN+1. Quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1).
//   Divide by zero: quotient = all ones, REM/REMU = rs1; done at N+1, no DIV state.
//   Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = rs1, REM = 0; done at N+1.
//  While in MUL/DIV: in_ready=0; operands latched at accept, so input changes are ignored.
//  Output stall: rd/eq/illegal/out_valid hold while out_valid && !out_ready; FSM finishing an op while a
//   result is still pending does not occur (in_ready gated on output).
//  Handoff and new accept in the same cycle: new result replaces old at the next edge, out_valid stays 1.
//  rst_n low in any cycle (incl. mid-MUL/DIV or while out_valid): reset values at next edge.
// TESTING
//  ADD 0x7FFFFFFF+1 then SUB 0-1 back-to-back, out_ready=1 -> rd 0x80000000 then 0xFFFFFFFF, 2 cycles.
//  SRA 0x80000000 by rs2=0x21 -> shamt 1, rd=0xC0000000; SLT -1<1 -> 1; SLTU -1<1 -> 0.
//  MULH 0x80000000*0x80000000 -> rd=0x40000000, out_valid exactly 33 cycles after accept, in_ready 0 meanwhile.
//  DIV 7/-2 -> -3; REM 7/-2 -> 1; DIVU x/0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 -> 0x80000000.
//  Hold out_ready=0 for 5 cycles after result -> rd, out_valid stable, in_ready=0; release -> handoff.
//  Assert rst_n=0 mid-DIV (cycle 10) -> next cycle out_valid=0, in_ready=1; no stale result appears.

Source files
------------

// File: rtl/alu_mdu.sv
// Integer ALU with RISC-V M extension: single-cycle base ops, iterative shift-add multiply
// and restoring divide behind a valid/ready handshake.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            eq,
    output logic            illegal
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state, state_n;
    logic [SHW-1:0]  cnt, cnt_n;
    logic [2:0]      op, op_n;
    logic            neg_a, neg_a_n;     // negate product / quotient
    logic            neg_b, neg_b_n;     // negate remainder
    logic            eq_p, eq_p_n;
    logic [XLEN-1:0] opb, opb_n;         // multiplicand or divisor magnitude
    logic [PW-1:0]   prod, prod_n;       // {hi, lo} product, or {remainder, quotient}
    logic            out_valid_n, eq_n, illegal_n;
    logic [XLEN-1:0] rd_n;

    logic            accept, is_m, s1, s2, sgn1, sgn2, base_ill, dge;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] mag1, mag2, base_res, rem_s, quo_s, qfix, rfix;
    logic [XLEN:0]   msum, dsh, ddiff;
    logic [PW-1:0]   pstep, pfix;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_m     = (funct7 == 7'b0000001);
    assign shamt    = rs2[SHW-1:0];

    // Operand signedness and magnitudes for the M-extension ops
    always_comb begin
        if (funct3[2]) begin
            s1 = !funct3[0];
            s2 = !funct3[0];
        end else begin
            s1 = (funct3 == 3'b001) || (funct3 == 3'b010);
            s2 = (funct3 == 3'b001);
        end
        sgn1 = s1 && rs1[XLEN-1];
        sgn2 = s2 && rs2[XLEN-1];
        mag1 = sgn1 ? (~rs1 + XLEN'(1)) : rs1;
        mag2 = sgn2 ? (~rs2 + XLEN'(1)) : rs2;
    end

    // Single-cycle base operations
    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (funct7)
            7'b0000000: begin
                case (funct3)
                    3'b000:  base_res = rs1 + rs2;
                    3'b001:  base_res = rs1 << shamt;
                    3'b010:  base_res = XLEN'($signed(rs1) < $signed(rs2));
                    3'b011:  base_res = XLEN'(rs1 < rs2);
                    3'b100:  base_res = rs1 ^ rs2;
                    3'b101:  base_res = rs1 >> shamt;
                    3'b110:  base_res = rs1 | rs2;
                    default: base_res = rs1 & rs2;
                endcase
            end
            7'b0100000: begin
                case (funct3)
                    3'b000:  base_res = rs1 - rs2;
                    3'b101:  base_res = XLEN'($signed(rs1) >>> shamt);
                    default: base_ill = 1'b1;
                endcase
            end
            default: base_ill = 1'b1;
        endcase
    end

    // One multiply step (add-then-shift) and one restoring-divide step
    always_comb begin
        msum  = {1'b0, prod[PW-1:XLEN]} + {1'b0, opb};
        pstep = prod[0] ? {msum, prod[XLEN-1:1]} : {1'b0, prod[PW-1:1]};
        pfix  = neg_a ? (~pstep + PW'(1)) : pstep;
        dsh   = prod[PW-1:XLEN-1];
        ddiff = dsh - {1'b0, opb};
        dge   = !ddiff[XLEN];
        rem_s = dge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0];
        quo_s = {prod[XLEN-2:0], dge};
        qfix  = neg_a ? (~quo_s + XLEN'(1)) : quo_s;
        rfix  = neg_b ? (~rem_s + XLEN'(1)) : rem_s;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        op_n        = op;
        neg_a_n     = neg_a;
        neg_b_n     = neg_b;
        eq_p_n      = eq_p;
        opb_n       = opb;
        prod_n      = prod;
        out_valid_n = out_valid && !out_ready;
        rd_n        = rd;
        eq_n        = eq;
        illegal_n   = illegal;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_m) begin
                        rd_n        = base_ill ? '0 : base_res;
                        eq_n        = (rs1 == rs2);
                        illegal_n   = base_ill;
                        out_valid_n = 1'b1;
                    end else if (!funct3[2]) begin
                        state_n = MUL;
                        cnt_n   = '0;
                        op_n    = funct3;
                        neg_a_n = sgn1 ^ sgn2;
                        opb_n   = mag1;
                        prod_n  = {XLEN'(0), mag2};
                        eq_p_n  = (rs1 == rs2);
                    end else if (rs2 == '0) begin
                        rd_n        = funct3[1] ? rs1 : '1;
                        eq_n        = (rs1 == rs2);
                        illegal_n   = 1'b0;
                        out_valid_n = 1'b1;
                    end else if (!funct3[0] && (rs1 == SMIN) && (rs2 == '1)) begin
                        rd_n        = funct3[1] ? '0 : rs1;
                        eq_n        = 1'b0;
                        illegal_n   = 1'b0;
                        out_valid_n = 1'b1;
                    end else begin
                        state_n = DIV;
                        cnt_n   = '0;
                        op_n    = funct3;
                        neg_a_n = sgn1 ^ sgn2;
                        neg_b_n = sgn1;
                        opb_n   = mag2;
                        prod_n  = {XLEN'(0), mag1};
                        eq_p_n  = (rs1 == rs2);
                    end
                end
            end
            MUL: begin
                prod_n = pstep;
                cnt_n  = cnt + SHW'(1);
                if (cnt == SHW'(XLEN - 1)) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b1;
                    rd_n        = (op == 3'b000) ? pfix[XLEN-1:0] : pfix[PW-1:XLEN];
                    eq_n        = eq_p;
                    illegal_n   = 1'b0;
                end
            end
            DIV: begin
                prod_n = {rem_s, quo_s};
                cnt_n  = cnt + SHW'(1);
                if (cnt == SHW'(XLEN - 1)) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b1;
                    rd_n        = op[1] ? rfix : qfix;
                    eq_n        = eq_p;
                    illegal_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            eq_p      <= 1'b0;
            opb       <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
            rd        <= '0;
            eq        <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op        <= op_n;
            neg_a     <= neg_a_n;
            neg_b     <= neg_b_n;
            eq_p      <= eq_p_n;
            opb       <= opb_n;
            prod      <= prod_n;
            out_valid <= out_valid_n;
            rd        <= rd_n;
            eq        <= eq_n;
            illegal   <= illegal_n;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32): directed corner cases, handshake scenarios
// and randomized ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, eq, illegal;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, rd;
    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        logic [7:0]  lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct7(funct7), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .eq(eq), .illegal(illegal)
    );

    // Reference model: result, illegal flag and accept-to-valid latency from plain arithmetic
    function automatic void model(input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; ill = 1'b0; lat = 1;
        if (f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h20) begin
            if (f3 == 3'd0) r = a - b;
            else if (f3 == 3'd5) begin sp = sa >>> b[4:0]; r = sp[31:0]; end
            else ill = 1'b1;
        end else if (f7 == 7'h01) begin
            if (f3 < 3'd4) begin
                lat = 33;
                case (f3)
                    3'd0: begin sp = sa * sb; r = sp[31:0]; end
                    3'd1: begin sp = sa * sb; r = sp[63:32]; end
                    3'd2: begin sp = sa * longint'({32'd0, b}); r = sp[63:32]; end
                    default: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
                endcase
            end else if (b == 32'd0) begin
                r = f3[1] ? a : 32'hFFFF_FFFF;
            end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = f3[1] ? 32'd0 : a;
            end else begin
                lat = 33;
                if (f3[0]) r = f3[1] ? (a % b) : (a / b);
                else begin sp = f3[1] ? (sa % sb) : (sa / sb); r = sp[31:0]; end
            end
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Drive one op, wait for its result; lat = cycles from accept edge to out_valid (-1 on timeout)
    task automatic do_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output logic e,
                         output logic il, output int lat, output logic busy_ok);
        int guard;
        @(negedge clk);
        funct7 = f7; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        lat = -1; busy_ok = 1'b1; r = 'x; e = 'x; il = 'x;
        if (!in_ready) return;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                in_valid = 1'b0;
                funct7 = 7'($urandom); funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
            end
            lat++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
        r = rd; e = eq; il = illegal;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct7 = '0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rd !== 32'd0 || eq !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: out_valid=%b rd=%h eq=%b illegal=%b in_ready=%b, want 0 0 0 0 1",
                     out_valid, rd, eq, illegal, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        funct7 = 7'h00; funct3 = 3'd0; rs1 = 32'h7FFF_FFFF; rs2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'h8000_0000) begin
            failures++; $display("FAIL b2b_add: out_valid=%b rd=%h want 1 80000000", out_valid, rd);
        end
        funct7 = 7'h20; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL b2b_sub: out_valid=%b rd=%h want 1 ffffffff", out_valid, rd);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] r; logic e, il, bz; int lat;
        v.push_back(vec_t'{7'h20, 3'd5, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h00, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h00, 3'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h01, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h01, 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h01, 3'd6, 32'd7, 32'hFFFF_FFFE, 32'h1, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h01, 3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h01, 3'd7, 32'd5, 32'h0, 32'd5, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 8'd1});
        v.push_back(vec_t'{7'h01, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8'd33});
        v.push_back(vec_t'{7'h20, 3'd1, 32'h5, 32'h6, 32'h0, 1'b1, 8'd1});
        v.push_back(vec_t'{7'h7F, 3'd0, 32'h5, 32'h5, 32'h0, 1'b1, 8'd1});
        foreach (v[i]) begin
            do_op(v[i].f7, v[i].f3, v[i].a, v[i].b, r, e, il, lat, bz);
            checks++;
            if (r !== v[i].exp || il !== v[i].ill || lat != int'(v[i].lat) || !bz) begin
                failures++;
                $display("FAIL directed[%0d]: rd=%h illegal=%b lat=%0d busy_ok=%b, want rd=%h illegal=%b lat=%0d busy_ok=1",
                         i, r, il, lat, bz, v[i].exp, v[i].ill, v[i].lat);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        funct7 = 7'h00; funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h1111; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        funct3 = 3'd4;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'h2345) begin
            failures++; $display("FAIL stall_first: out_valid=%b rd=%h want 1 00002345", out_valid, rd);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || rd !== 32'h2345 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out_valid=%b rd=%h in_ready=%b want 1 00002345 0",
                         i, out_valid, rd, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'h0325) begin
            failures++; $display("FAIL stall_replace: out_valid=%b rd=%h want 1 00000325", out_valid, rd);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_div();
        logic stale;
        logic [31:0] r; logic e, il, bz; int lat;
        do_op(7'h00, 3'd6, 32'hA5A5_0000, 32'h0000_5A5A, r, e, il, lat, bz);
        @(negedge clk);
        funct7 = 7'h01; funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        repeat (10) begin @(negedge clk); in_valid = 1'b0; end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_div: out_valid=%b in_ready=%b rd=%h want 0 1 00000000", out_valid, in_ready, rd);
        end
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) stale = 1'b1; end
        checks++;
        if (stale !== 1'b0) begin failures++; $display("FAIL rst_stale: stale result seen=%b want 0", stale); end
        do_op(7'h01, 3'd4, 32'd100, 32'd7, r, e, il, lat, bz);
        checks++;
        if (r !== 32'd14 || lat != 33) begin
            failures++; $display("FAIL rst_recover: rd=%h lat=%0d want 0000000e 33", r, lat);
        end
    endtask

    task automatic test_random();
        logic [6:0] f7; logic [2:0] f3; logic [31:0] a, b, r, er; logic e, il, eil, bz;
        int lat, elat;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: f7 = 7'h00;
                3, 4:    f7 = 7'h20;
                9:       f7 = 7'($urandom);
                default: f7 = 7'h01;
            endcase
            f3 = 3'($urandom);
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
            model(f7, f3, a, b, er, eil, elat);
            do_op(f7, f3, a, b, r, e, il, lat, bz);
            checks++;
            if (r !== er || il !== eil || e !== (a == b) || lat != elat || !bz) begin
                failures++;
                $display("FAIL random[%0d] f7=%h f3=%0d a=%h b=%h: rd=%h ill=%b eq=%b lat=%0d busy_ok=%b, want rd=%h ill=%b eq=%b lat=%0d",
                         i, f7, f3, a, b, r, il, e, lat, bz, er, eil, (a == b), elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_stall();
        test_reset_mid_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
